sa_fifo_loader: RTL

- Upstream control stage for the systolic-array input FIFO.
- Accepts matrix rows from the operand buffer over a valid/ready handshake and loads exactly array_dim rows into the FIFO.
- Once loaded, waits for start, then issues array_dim shift pulses (stallable) to stream the rows into the array.
- Signals completion with a one-cycle done pulse and re-arms for the next tile.

---
 rtl/sa_fifo_loader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sa_fifo_loader.sv
// -----------------------------------------------------------------------------
// sa_fifo_loader
//
// Upstream control stage for the systolic-array input FIFO. Collects exactly
// array_dim rows from the operand buffer over a valid/ready handshake and
// presents each one to the FIFO with a load strobe. When the tile is complete
// it waits for start, then issues array_dim stallable shift strobes to stream
// the rows into the array, pulses done for one cycle and re-arms.
//
// Ports
//   CLK          clock
//   nRST         asynchronous active-low reset
//   row_valid    upstream row available
//   row_data     one matrix row, element 0 in bits [data_w-1:0]
//   row_ready    loader accepts a row this cycle (decoded from state/count)
//   start        array controller requests streaming of the loaded tile
//   stall        array back-pressure, suppresses shift while high
//   abort        synchronous tile cancel, returns to LOAD
//   load         FIFO load strobe (registered)
//   shift        FIFO shift strobe (registered)
//   load_values  row presented to the FIFO with load (registered)
//   armed        tile fully loaded, awaiting start
//   done         one-cycle pulse the cycle after the final shift is visible
// -----------------------------------------------------------------------------
module sa_fifo_loader #(
    parameter int array_dim = 4,
    parameter int data_w    = 16
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          row_valid,
    input  logic [data_w*array_dim-1:0]   row_data,
    output logic                          row_ready,
    input  logic                          start,
    input  logic                          stall,
    input  logic                          abort,
    output logic                          load,
    output logic                          shift,
    output logic [data_w*array_dim-1:0]   load_values,
    output logic                          armed,
    output logic                          done
);

    localparam int CNT_W = $clog2(array_dim + 1);
    localparam logic [CNT_W-1:0] DIM_C  = CNT_W'(array_dim);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                         state_r;
    logic [CNT_W-1:0]               row_cnt_r;
    logic [CNT_W-1:0]               shift_cnt_r;
    logic                           load_r;
    logic                           shift_r;
    logic                           done_r;
    logic [data_w*array_dim-1:0]    load_values_r;

    logic                           row_ready_s;
    logic                           fire_s;
    logic                           armed_s;

    // Handshake decode: ready depends only on state and row count, never on valid.
    always_comb begin
        row_ready_s = 1'b0;
        armed_s     = 1'b0;
        if (state_r == ST_LOAD) begin
            row_ready_s = (row_cnt_r < DIM_C);
        end else begin
            row_ready_s = 1'b0;
        end
        if (state_r == ST_ARMED) begin
            armed_s = 1'b1;
        end else begin
            armed_s = 1'b0;
        end
        fire_s = row_valid & row_ready_s;
    end

    // Tile sequencer: state, counters and all registered strobes.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r       <= ST_LOAD;
            row_cnt_r     <= ZERO_C;
            shift_cnt_r   <= ZERO_C;
            load_r        <= 1'b0;
            shift_r       <= 1'b0;
            done_r        <= 1'b0;
            load_values_r <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            load_r  <= 1'b0;
            shift_r <= 1'b0;
            done_r  <= 1'b0;
            if (abort) begin
                // A row handshaked alongside abort is dropped; FIFO contents stay.
                state_r     <= ST_LOAD;
                row_cnt_r   <= ZERO_C;
                shift_cnt_r <= ZERO_C;
            end else begin
                case (state_r)
                    ST_LOAD: begin
                        if (fire_s) begin
                            load_r        <= 1'b1;
                            load_values_r <= row_data;
                            if (row_cnt_r == (DIM_C - ONE_C)) begin
                                state_r   <= ST_ARMED;
                                row_cnt_r <= ZERO_C;
                            end else begin
                                row_cnt_r <= row_cnt_r + ONE_C;
                            end
                        end else begin
                            row_cnt_r <= row_cnt_r;
                        end
                    end
                    ST_ARMED: begin
                        if (start) begin
                            state_r <= ST_SHIFT;
                        end else begin
                            state_r <= ST_ARMED;
                        end
                    end
                    ST_SHIFT: begin
                        // Leave only once the last shift strobe is already on the
                        // output, so done lands on the cycle after it.
                        if (shift_cnt_r == DIM_C) begin
                            state_r     <= ST_DONE;
                            shift_cnt_r <= ZERO_C;
                            done_r      <= 1'b1;
                        end else if (!stall) begin
                            shift_r     <= 1'b1;
                            shift_cnt_r <= shift_cnt_r + ONE_C;
                        end else begin
                            shift_cnt_r <= shift_cnt_r;
                        end
                    end
                    ST_DONE: begin
                        state_r     <= ST_LOAD;
                        row_cnt_r   <= ZERO_C;
                        shift_cnt_r <= ZERO_C;
                    end
                    default: begin
                        state_r     <= ST_LOAD;
                        row_cnt_r   <= ZERO_C;
                        shift_cnt_r <= ZERO_C;
                    end
                endcase
            end
        end
    end

    assign row_ready   = row_ready_s;
    assign armed       = armed_s;
    assign load        = load_r;
    assign shift       = shift_r;
    assign done        = done_r;
    assign load_values = load_values_r;

endmodule
